// File: rtl/stride_prefetcher_pkg.sv
// Shared types and constants for the PC-indexed stride prefetcher.
// Line size, stride/confidence widths and the pipeline-facing structs live here.
package stride_prefetcher_pkg;

  localparam int CLSIZE_E    = 6;
  localparam int LINE_W      = 32 - CLSIZE_E;
  localparam int STRIDE_W    = 8;
  localparam int CONF_W      = 2;
  localparam int CONF_THRESH = 2;
  localparam int TAG_W       = 14;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] addr;
  } MemAccess;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } Prefetch;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } Prefetch_ACK;

  // Tag is pc[15:2] shifted down by the index width, so upper tag bits are zero.
  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [LINE_W-1:0]   lastLine;
    logic [STRIDE_W-1:0] stride;
    logic [CONF_W-1:0]   conf;
  } StrideEntry;

  function automatic logic [LINE_W-1:0] sext_stride(input logic [STRIDE_W-1:0] s);
    return {{(LINE_W - STRIDE_W){s[STRIDE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides and a clear input.
// Accepts a push while full when the head is popped in the same cycle.
module prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o,
  input  logic             out_rdy_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] tail_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign out_vld_o = !empty_o;
  assign in_rdy_o  = !full_o || out_rdy_i;
  assign do_push   = in_vld_i && in_rdy_o;
  assign do_pop    = out_vld_o && out_rdy_i;
  assign tail_ptr  = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);
  assign out_dat_o = mem_q[rd_ptr_q];
  assign tail_o    = mem_q[tail_ptr];
  assign count_o   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = nxt(wr_ptr_q);
    if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_dat_i;
  end

endmodule

// File: rtl/stride_prefetcher.sv
// PC-indexed stride prefetcher: access registered at E0, table updated and candidate queued at E1.
// Candidates are dropped (never stalled) on full queue, outstanding budget, or repeat of queue tail.
module stride_prefetcher
  import stride_prefetcher_pkg::*;
#(
  parameter int NUM_ENTRIES     = 8,
  parameter int QUEUE_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  MemAccess    IN_access,
  input  logic        IN_flush,
  output Prefetch     OUT_prefetch,
  input  logic        IN_prefetchReady,
  input  Prefetch_ACK IN_prefetchAck
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  MemAccess          acc_q, acc_d;
  StrideEntry        tbl_q [NUM_ENTRIES];
  StrideEntry        ent, new_ent;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic [LINE_W-1:0] line, delta, cand_line;
  logic [31:0]       cand_addr;
  logic              hit, in_rng, upd_en, issue, budget_ok, dup, enq, deq, ack_ok;
  logic [OUT_W-1:0]  outst_q, outst_d;

  logic              fifo_in_rdy, fifo_out_vld, fifo_full, fifo_empty;
  logic [31:0]       fifo_out_dat, fifo_tail;
  logic [CNT_W-1:0]  fifo_cnt;

  // Access stage; an access arriving with a flush is discarded.
  always_comb begin
    acc_d = IN_access;
    if (IN_flush) acc_d.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q.valid <= 1'b0;
    else     acc_q <= acc_d;
  end

  assign idx    = acc_q.pc[IDX_W+1:2];
  assign tag_in = acc_q.pc[15:2] >> IDX_W;
  assign line   = acc_q.addr[31:CLSIZE_E];
  assign ent    = tbl_q[idx];
  assign hit    = ent.valid && (ent.tag == tag_in);
  assign delta  = line - ent.lastLine;
  assign in_rng = (delta[LINE_W-1:STRIDE_W-1] == '0) || (delta[LINE_W-1:STRIDE_W-1] == '1);

  always_comb begin
    new_ent          = ent;
    new_ent.valid    = 1'b1;
    new_ent.lastLine = line;
    if (!hit) begin
      new_ent.tag    = tag_in;
      new_ent.stride = '0;
      new_ent.conf   = '0;
    end else if (!in_rng) begin
      new_ent.stride = '0;
      new_ent.conf   = '0;
    end else if (delta == sext_stride(ent.stride)) begin
      if (ent.conf != '1) new_ent.conf = ent.conf + CONF_W'(1);
    end else begin
      new_ent.stride = delta[STRIDE_W-1:0];
      new_ent.conf   = '0;
    end
  end

  // Flops rather than RAM: an access on the next cycle reads the entry already written here.
  assign upd_en = acc_q.valid && !IN_flush;

  always_ff @(posedge clk) begin
    if (rst || IN_flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else if (upd_en) begin
      tbl_q[idx] <= new_ent;
    end
  end

  assign issue     = upd_en && (new_ent.conf >= CONF_W'(CONF_THRESH)) && (new_ent.stride != '0);
  assign cand_line = line + sext_stride(new_ent.stride);
  assign cand_addr = {cand_line, {CLSIZE_E{1'b0}}};
  assign budget_ok = (32'(outst_q) + 32'(fifo_cnt)) < 32'(MAX_OUTSTANDING);
  assign dup       = !fifo_empty && (fifo_tail == cand_addr);
  assign enq       = issue && fifo_in_rdy && budget_ok && !dup;
  assign deq       = fifo_out_vld && IN_prefetchReady;

  prefetch_fifo #(
    .WIDTH (32),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (IN_flush),
    .in_vld_i  (enq),
    .in_dat_i  (cand_addr),
    .in_rdy_o  (fifo_in_rdy),
    .out_vld_o (fifo_out_vld),
    .out_dat_o (fifo_out_dat),
    .out_rdy_i (IN_prefetchReady),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt),
    .tail_o    (fifo_tail)
  );

  always_comb begin
    OUT_prefetch.valid = fifo_out_vld;
    OUT_prefetch.addr  = fifo_out_dat;
  end

  // Outstanding count survives a flush; acks with nothing outstanding are ignored.
  assign ack_ok = IN_prefetchAck.valid && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (deq && !ack_ok)      outst_d = outst_q + OUT_W'(1);
    else if (!deq && ack_ok) outst_d = outst_q - OUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) outst_q <= '0;
    else     outst_q <= outst_d;
  end

  logic unused_bits;
  assign unused_bits = ^{acc_q.pc[31:16], acc_q.pc[1:0], acc_q.addr[CLSIZE_E-1:0],
                         IN_prefetchAck.addr, fifo_full};

endmodule

// File: tb/tb_stride_prefetcher.sv
// Directed bench for stride_prefetcher: each task drives one scenario and checks inline.
module tb_stride_prefetcher;
  import stride_prefetcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  MemAccess    acc;
  logic        flush;
  Prefetch     pf;
  logic        rdy;
  Prefetch_ACK ack;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  stride_prefetcher #(
    .NUM_ENTRIES     (8),
    .QUEUE_DEPTH     (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_access        (acc),
    .IN_flush         (flush),
    .OUT_prefetch     (pf),
    .IN_prefetchReady (rdy),
    .IN_prefetchAck   (ack)
  );

  // Every handshake completed on the prefetch port, in order.
  always @(negedge clk) if (!rst && pf.valid && rdy) got.push_back(pf.addr);

  function automatic logic [31:0] gq(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxxxxxx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic access(input logic [31:0] pc, input logic [31:0] a);
    acc = '{valid: 1'b1, pc: pc, addr: a};
    step();
    acc.valid = 1'b0;
  endtask

  task automatic acks(input int n);
    ack.valid = 1'b1;
    repeat (n) step();
    ack.valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rdy = 1'b0;
    acc = '0; ack = '0;
    idle(3);
    checks++; if (pf.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pf.valid); end
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL reset_outst: got %0d want 0", dut.outst_q); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    rdy = 1'b1; got.delete();
    access(32'h100, 32'h1000); access(32'h100, 32'h1040);
    access(32'h100, 32'h1080); access(32'h100, 32'h10C0);
    checks++; if (pf.valid !== 1'b0) begin errors++; $display("FAIL stream_early: valid %b want 0", pf.valid); end
    step();
    checks++; if (pf.valid !== 1'b1 || pf.addr !== 32'h1100) begin errors++; $display("FAIL stream_issue: valid %b addr %h want 1 00001100", pf.valid, pf.addr); end
    step();
    checks++; if (pf.valid !== 1'b0) begin errors++; $display("FAIL stream_drained: valid %b want 0", pf.valid); end
    idle(3);
    checks++; if (got.size() !== 1) begin errors++; $display("FAIL stream_count: got %0d want 1", got.size()); end
    acks(1);
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL stream_outst: got %0d want 0", dut.outst_q); end
  endtask

  task automatic test_stride_zero();
    got.delete();
    repeat (4) access(32'h104, 32'h2000);
    idle(4);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL stride0_none: got %0d want 0", got.size()); end
  endtask

  task automatic test_queue_full();
    rdy = 1'b0; got.delete();
    for (int k = 0; k < 9; k++) access(32'h108, 32'h3000 + 32'(k) * 32'h40);
    idle(2);
    checks++; if (pf.valid !== 1'b1 || pf.addr !== 32'h3100) begin errors++; $display("FAIL qfull_head: valid %b addr %h want 1 00003100", pf.valid, pf.addr); end
    rdy = 1'b1;
    idle(4);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL qfull_count: got %0d want 2", got.size()); end
    checks++; if (gq(0) !== 32'h3100) begin errors++; $display("FAIL qfull_first: got %h want 00003100", gq(0)); end
    checks++; if (gq(1) !== 32'h3140) begin errors++; $display("FAIL qfull_second: got %h want 00003140", gq(1)); end
    checks++; if (int'(dut.outst_q) !== 2) begin errors++; $display("FAIL qfull_outst: got %0d want 2", dut.outst_q); end
  endtask

  task automatic test_outstanding();
    got.delete();
    for (int k = 9; k < 13; k++) access(32'h108, 32'h3000 + 32'(k) * 32'h40);
    idle(4);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL outst_count: got %0d want 2", got.size()); end
    checks++; if (gq(0) !== 32'h3280 || gq(1) !== 32'h32C0) begin errors++; $display("FAIL outst_addrs: got %h %h want 00003280 000032c0", gq(0), gq(1)); end
    checks++; if (int'(dut.outst_q) !== 4) begin errors++; $display("FAIL outst_cap: got %0d want 4", dut.outst_q); end
    acks(1);
    checks++; if (int'(dut.outst_q) !== 3) begin errors++; $display("FAIL outst_ack: got %0d want 3", dut.outst_q); end
    access(32'h108, 32'h3000 + 32'd13 * 32'h40);
    idle(3);
    checks++; if (got.size() !== 3 || gq(2) !== 32'h3380) begin errors++; $display("FAIL outst_resume: count %0d addr %h want 3 00003380", got.size(), gq(2)); end
    acks(4);
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL outst_clear: got %0d want 0", dut.outst_q); end
  endtask

  task automatic test_flush();
    rdy = 1'b0; got.delete();
    for (int k = 0; k < 5; k++) access(32'h10C, 32'h5000 + 32'(k) * 32'h40);
    idle(1);
    checks++; if (pf.valid !== 1'b1) begin errors++; $display("FAIL flush_prequeued: valid %b want 1", pf.valid); end
    flush = 1'b1;
    acc = '{valid: 1'b1, pc: 32'h10C, addr: 32'h5140};
    step();
    flush = 1'b0; acc.valid = 1'b0;
    checks++; if (pf.valid !== 1'b0) begin errors++; $display("FAIL flush_empty: valid %b want 0", pf.valid); end
    rdy = 1'b1;
    for (int k = 6; k < 9; k++) access(32'h10C, 32'h5000 + 32'(k) * 32'h40);
    idle(3);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL flush_relearn: got %0d want 0", got.size()); end
    access(32'h10C, 32'h5000 + 32'd9 * 32'h40);
    idle(3);
    checks++; if (got.size() !== 1 || gq(0) !== 32'h5280) begin errors++; $display("FAIL flush_reissue: count %0d addr %h want 1 00005280", got.size(), gq(0)); end
    acks(1);
  endtask

  task automatic test_wrap();
    rdy = 1'b1; got.delete();
    access(32'h110, 32'h100); access(32'h110, 32'hC0); access(32'h110, 32'h80);
    access(32'h110, 32'h40);  access(32'h110, 32'h0);
    idle(4);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", got.size()); end
    checks++; if (gq(0) !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", gq(0)); end
    checks++; if (gq(1) !== 32'hFFFFFFC0) begin errors++; $display("FAIL wrap_neg: got %h want ffffffc0", gq(1)); end
    acks(2);
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL wrap_outst: got %0d want 0", dut.outst_q); end
  endtask

  task automatic test_back_to_back();
    rdy = 1'b0; got.delete();
    for (int n = 0; n < 4; n++) begin
      access(32'h114, 32'h6000 + 32'(n) * 32'h40);
      access(32'h118, 32'h6000 + 32'(n) * 32'h40);
    end
    idle(2);
    rdy = 1'b1;
    idle(3);
    checks++; if (got.size() !== 1 || gq(0) !== 32'h6100) begin errors++; $display("FAIL dedupe: count %0d addr %h want 1 00006100", got.size(), gq(0)); end
    checks++; if (int'(dut.outst_q) !== 1) begin errors++; $display("FAIL dedupe_outst: got %0d want 1", dut.outst_q); end
  endtask

  task automatic test_reset_midstream();
    rdy = 1'b0; got.delete();
    for (int k = 0; k < 5; k++) access(32'h11C, 32'h7000 + 32'(k) * 32'h40);
    idle(1);
    checks++; if (pf.valid !== 1'b1) begin errors++; $display("FAIL midrst_queued: valid %b want 1", pf.valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (pf.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: valid %b want 0", pf.valid); end
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL midrst_outst: got %0d want 0", dut.outst_q); end
    rdy = 1'b1;
    idle(3);
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL midrst_drain: got %0d want 0", got.size()); end
    acks(1);
    checks++; if (int'(dut.outst_q) !== 0) begin errors++; $display("FAIL midrst_underflow: got %0d want 0", dut.outst_q); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stride_zero();
    test_queue_full();
    test_outstanding();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stride_prefetcher.md
STRIDE_PREFETCHER -- requirements
Module: stride_prefetcher

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, meaning number of PC-indexed stride table entries (power of two).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, meaning depth of the outgoing prefetch FIFO.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum issued-but-unacknowledged prefetches.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_access  input  struct {valid, pc[31:0], addr[31:0]}  committed-address load access observed from the load pipeline.
REQ-007 SHALL have port IN_flush  input  1  invalidates the table and the queue.
REQ-008 SHALL have port OUT_prefetch  output  Prefetch  {valid, addr[31:0]}  request to the cache line manager.
REQ-009 SHALL have port IN_prefetchReady  input  1  the cache line manager accepts OUT_prefetch this cycle.
REQ-010 SHALL have port IN_prefetchAck  input  Prefetch_ACK  completion of one earlier prefetch; only .valid is used.

Function
REQ-011 Line address SHALL be addr[31:CLSIZE_E]; index = pc[log2(NUM_ENTRIES)+1:2]; tag = pc[15:log2(NUM_ENTRIES)+2].
REQ-012 Entry fields SHALL be: valid, tag, lastLine, stride (8-bit signed, in lines), conf (2-bit saturating).
REQ-013 A valid access SHALL be registered at edge E0, and the table is read and updated at edge E1.
REQ-014 Tag miss or invalid entry: write tag, lastLine=line, stride=0, conf=0.
REQ-015 Tag hit with delta = line-lastLine: if delta equals stride, conf++ (saturate at 3); otherwise stride=delta and conf=0; lastLine=line in both cases.
REQ-016 Delta outside [-128,127]: stride=0, conf=0.
REQ-017 Issue condition after update: conf>=2 and stride!=0; the candidate address is ((line+stride) mod 2^(32-CLSIZE_E)) << CLSIZE_E, wrapping silently.
REQ-018 The candidate SHALL be enqueued at E1, so OUT_prefetch.valid is visible from the cycle after E1 (2-cycle latency from access).
REQ-019 The candidate SHALL be dropped if any of: queue full; outstanding+queued >= MAX_OUTSTANDING; addr equals the queue tail entry.
REQ-020 OUT_prefetch SHALL present the queue head; it is dequeued at an edge where valid && IN_prefetchReady.
REQ-021 OUT_prefetch.valid=0 SHALL force OUT_prefetch.addr to don't-care.
REQ-022 Simultaneous enqueue and dequeue on a full queue SHALL be allowed: the head leaves and the candidate enters.
REQ-023 Outstanding counter: +1 per dequeue and -1 per IN_prefetchAck.valid; both in one cycle leaves it unchanged; it never underflows (ack at 0 is ignored).
REQ-024 IN_flush SHALL clear all entry valid bits, the queue, and the access stage register at the next edge, while preserving the outstanding counter.
REQ-025 An access coincident with IN_flush SHALL be discarded.
REQ-026 Two accesses to the same index on consecutive cycles SHALL see the first update, via forwarding from the E1 write.

Reset
REQ-027 On rst the block SHALL clear all entry valid bits, empty the queue, clear the access stage register and set outstanding=0.
REQ-028 On rst OUT_prefetch.valid SHALL be 0 in the next cycle.
REQ-029 Entry data fields SHALL have no reset value.
REQ-030 rst asserted mid-stream SHALL discard queued requests, and acks received after reset SHALL be ignored while outstanding=0.

Structure
REQ-031 Shared package SHALL hold: the StrideEntry struct, STRIDE_W=8, CONF_W=2, CONF_THRESH=2, Prefetch and Prefetch_ACK (existing).
REQ-032 The outgoing queue SHALL be a sub-module, prefetch_fifo (parameterised width/depth, valid/ready, full/empty outputs).
REQ-033 The table SHALL be flops (no RAM macro) to permit same-cycle forwarding.

Verification
REQ-034 CLSIZE_E=6, pc=0x100, addrs 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles, ready=1: exactly one prefetch, addr 0x1100, two cycles after the 0x10C0 access.
REQ-035 Same PC, addrs 0x2000, 0x2000, 0x2000, 0x2000 (stride 0): no prefetch.
REQ-036 Confident stream, ready=0, then 5 more accesses: queue holds 2, rest dropped; ready=1 drains 2 in order; outstanding=2.
REQ-037 4 dequeues without ack, then further confident accesses: no enqueue; one ack: next candidate enqueued.
REQ-038 Conf=3 stream, then IN_flush with access same cycle: queue empties, next access re-allocates with conf=0, no prefetch until the third matching delta.
REQ-039 Stride -1 from addr 0x00000000: prefetch addr 0xFFFFFFC0 (wrap).
